mem_ctrl: RTL and testbench
===========================

MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameter: ADDR_W, 2, memory address width in bits.
REQ-002 Parameter: DATA_W, 8, memory data width in bits.
REQ-003 Port: clock  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: req_valid  input  1  request present.
REQ-006 Port: req_ready  output  1  controller can accept a request.
REQ-007 Port: req_op  input  1  operation: 0 = read, 1 = write.
REQ-008 Port: req_addr  input  ADDR_W  target address.
REQ-009 Port: req_wdata  input  DATA_W  write data.
REQ-010 Port: rsp_valid  output  1  response present.
REQ-011 Port: rsp_ready  input  1  consumer accepts the response.
REQ-012 Port: rsp_rdata  output  DATA_W  read data; 0 for write responses.
REQ-013 Port: mem_wr  output  1  write strobe to the memory cell.
REQ-014 Port: mem_addr  output  ADDR_W  address to the memory cell.
REQ-015 Port: mem_wdata  output  DATA_W  write data to the memory cell.
REQ-016 Port: mem_rdata  input  DATA_W  registered read data from the memory cell, valid one cycle after the address is presented with mem_wr = 0.

Function
REQ-017 FSM states: INIT, IDLE, WRITE, RD_ISSUE, RD_WAIT, RESP.
REQ-018 req_ready = 1 only in IDLE; a request is accepted on the edge where req_valid && req_ready; op, addr and wdata are latched on that edge.
REQ-019 Accepted write: IDLE -> WRITE; WRITE drives mem_wr = 1 with the latched addr and wdata for exactly one cycle, then -> RESP; response arrives 2 cycles after acceptance.
REQ-020 Accepted read: IDLE -> RD_ISSUE (mem_wr = 0, latched addr) -> RD_WAIT (mem_rdata captured into rsp_rdata at the end of the cycle) -> RESP; response arrives 3 cycles after acceptance.
REQ-021 RESP: rsp_valid = 1; rsp_rdata is held stable until the edge where rsp_ready = 1, then -> IDLE; a new request is accepted no earlier than the following cycle.
REQ-022 mem_wr = 1 only in WRITE (and INIT when enabled); mem_wr = 0 in all other states.
REQ-023 mem_addr and mem_wdata hold their last driven values outside active states.
REQ-024 Back-to-back: no overlap; at most one transaction is in flight; req_valid is ignored outside IDLE.
REQ-025 req_valid held with rsp_ready tied high: sustained throughput is one write per 3 cycles or one read per 4 cycles.

Reset
REQ-026 While reset = 1: state -> INIT if MEM_CTRL_INIT_EN is defined, else IDLE; req_ready = 0 (during INIT), rsp_valid = 0, rsp_rdata = 0, mem_wr = 0, mem_addr = 0, mem_wdata = 0.
REQ-027 Reset asserted mid-transaction aborts it on that edge; no response is issued and any pending memory write strobe is dropped.

Configuration
REQ-028 Macro MEM_CTRL_INIT_EN defined: after reset, INIT writes 0 to every address 0..2^ADDR_W-1, one per cycle, ascending (mem_wr = 1); req_ready = 0 throughout; -> IDLE after the last address.
REQ-029 Macro MEM_CTRL_INIT_EN undefined: INIT is unreachable; reset -> IDLE with req_ready = 1 on the first cycle after reset deasserts.

Structure
REQ-030 Shared package mem_ctrl_pkg holds the FSM state typedef, the op encoding constants (OP_RD = 0, OP_WR = 1), and the default widths.
REQ-031 The block is a single module with no sub-module; the memory cell is instantiated only in the testbench.

Verification
REQ-032 Write addr 2 = 0xA5, then read addr 2 -> write response at +2 cycles with rsp_rdata = 0x00; read response at +3 cycles with rsp_rdata = 0xA5.
REQ-033 Write 0x11/0x22/0x33/0x44 to addresses 0..3, then read 3,2,1,0 -> responses 0x44, 0x33, 0x22, 0x11.
REQ-034 rsp_ready held at 0 for 5 cycles during a read of 0x5A -> rsp_valid and rsp_rdata = 0x5A stable, req_ready = 0, and no mem_wr pulse.
REQ-035 Reset pulsed in RD_ISSUE -> next cycle rsp_valid = 0, mem_wr = 0, and state is IDLE/INIT per macro.
REQ-036 With MEM_CTRL_INIT_EN: preload memory with 0xFF, reset -> four mem_wr pulses at addresses 0,1,2,3 with data 0x00, req_ready first high on cycle 5, and subsequent reads return 0x00.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg -- shared definitions for the single-port memory controller.
//   DEF_ADDR_W / DEF_DATA_W : default address / data widths
//   OP_RD / OP_WR           : request operation encoding
//   state_e                 : controller FSM state encoding
package mem_ctrl_pkg;

  localparam int DEF_ADDR_W = 2;
  localparam int DEF_DATA_W = 8;

  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_WRITE,
    ST_RD_ISSUE,
    ST_RD_WAIT,
    ST_RESP
  } state_e;

endpackage

// File: rtl/mem_ctrl.sv
// mem_ctrl -- one-transaction-at-a-time controller in front of a memory cell
// with a registered read port.
//
// Ports:
//   clock, reset           : rising-edge clock, synchronous active-high reset
//   req_valid/req_ready    : request handshake (ready only in IDLE)
//   req_op/addr/wdata      : operation (OP_RD/OP_WR), address, write data
//   rsp_valid/rsp_ready    : response handshake
//   rsp_rdata              : read data (0 for write responses)
//   mem_wr/addr/wdata      : strobe, address and data to the memory cell
//   mem_rdata              : registered read data from the cell
//
// Build option: define MEM_CTRL_INIT_EN to zero-fill every address after
// reset before the first request is accepted.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

`ifdef MEM_CTRL_INIT_EN
  localparam state_e RST_STATE = ST_INIT;
`else
  localparam state_e RST_STATE = ST_IDLE;
`endif

  state_e            state_q, state_d;
  // addr_q/wdata_q double as the request latch and the memory-side drivers,
  // so the cell sees the last driven values whenever the FSM is idle.
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      ST_INIT: begin
`ifdef MEM_CTRL_INIT_EN
        // wdata_q is zero out of reset; addr_q walks 0..2^ADDR_W-1.
        if (addr_q == {ADDR_W{1'b1}}) state_d = ST_IDLE;
        else                          addr_d  = addr_q + 1'b1;
`else
        state_d = ST_IDLE;
`endif
      end
      ST_IDLE: begin
        if (req_valid) begin
          addr_d = req_addr;
          // The path through the FSM carries the op, so it is not stored.
          if (req_op == OP_WR) begin
            wdata_d = req_wdata;
            rdata_d = '0;
            state_d = ST_WRITE;
          end else begin
            state_d = ST_RD_ISSUE;
          end
        end
      end
      ST_WRITE:    state_d = ST_RESP;
      ST_RD_ISSUE: state_d = ST_RD_WAIT;
      ST_RD_WAIT: begin
        rdata_d = mem_rdata;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= RST_STATE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Outputs are forced quiet while reset is high so an in-flight write
  // strobe or response is dropped in the very cycle reset is asserted.
  logic wr_state;
`ifdef MEM_CTRL_INIT_EN
  assign wr_state = (state_q == ST_WRITE) || (state_q == ST_INIT);
`else
  assign wr_state = (state_q == ST_WRITE);
`endif

  assign req_ready = !reset && (state_q == ST_IDLE);
  assign rsp_valid = !reset && (state_q == ST_RESP);
  assign mem_wr    = !reset && wr_state;
  assign rsp_rdata = reset ? '0 : rdata_q;
  assign mem_addr  = reset ? '0 : addr_q;
  assign mem_wdata = reset ? '0 : wdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl -- scoreboard bench for mem_ctrl with a behavioural memory
// cell. Acceptances push expected responses/strobes; a negedge monitor pops
// and compares whenever the DUT presents them.
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  localparam int AW = 2;
  localparam int DW = 8;
  localparam int NA = 1 << AW;
`ifdef MEM_CTRL_INIT_EN
  localparam int INIT_N = NA;
`else
  localparam int INIT_N = 0;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_op = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_ready = 1'b1;
  logic          req_ready, rsp_valid, mem_wr;
  logic [DW-1:0] rsp_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;

  always #5 clock = ~clock;

  mem_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Memory cell: synchronous write, registered read.
  logic [DW-1:0] mem [NA];
  always @(posedge clock) begin
    if (mem_wr) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  typedef struct { int due; logic [DW-1:0] d; } rsp_t;
  typedef struct { int due; logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;

  rsp_t          rsp_q[$];
  wr_t           wr_q[$];
  rsp_t          cur;
  wr_t           w;
  bit            have_cur = 0;
  logic [DW-1:0] model [NA];
  int            cyc = 0;
  int            init_left = 0;
  int            init_addr = 0;
  bit            post_rst = 0;
  int            n_chk = 0;
  int            n_fail = 0;
  int            rdy_mode = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail1(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: unexpected event at cycle %0d", nm, cyc);
  endtask

  // Monitor / scoreboard.
  always @(negedge clock) begin
    cyc++;
    if (reset) begin
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_rdata", rsp_rdata, 0);
      chk("rst_mem_wr",    mem_wr,    0);
      chk("rst_mem_addr",  mem_addr,  0);
      chk("rst_mem_wdata", mem_wdata, 0);
      rsp_q.delete();
      wr_q.delete();
      have_cur  = 0;
      init_left = INIT_N;
      init_addr = 0;
      post_rst  = 1;
`ifdef MEM_CTRL_INIT_EN
      for (int i = 0; i < NA; i++) model[i] = '0;
`endif
    end else if (init_left > 0) begin
      chk("init_wr",    mem_wr,    1);
      chk("init_addr",  mem_addr,  init_addr);
      chk("init_data",  mem_wdata, 0);
      chk("init_ready", req_ready, 0);
      init_addr++;
      init_left--;
    end else begin
      if (post_rst) begin
        chk("post_rst_ready", req_ready, 1);
        chk("post_rst_rsp",   rsp_valid, 0);
        post_rst = 0;
      end
      if (mem_wr) begin
        if (wr_q.size() == 0) fail1("spurious_mem_wr");
        else begin
          w = wr_q.pop_front();
          chk("wr_addr",  mem_addr,  w.a);
          chk("wr_data",  mem_wdata, w.d);
          chk("wr_cycle", cyc,       w.due);
        end
      end
      if (rsp_valid) begin
        if (!have_cur) begin
          if (rsp_q.size() == 0) fail1("spurious_rsp");
          else begin
            cur = rsp_q.pop_front();
            have_cur = 1;
            chk("rsp_latency", cyc, cur.due);
          end
        end
        if (have_cur) begin
          chk("rsp_rdata", rsp_rdata, cur.d);
          chk("rsp_no_wr", mem_wr,    0);
          chk("rsp_busy",  req_ready, 0);
          if (rsp_ready) have_cur = 0;
        end
      end
      if (req_valid && req_ready) begin
        if (req_op == OP_WR) begin
          model[req_addr] = req_wdata;
          wr_q.push_back('{cyc + 1, req_addr, req_wdata});
          rsp_q.push_back('{cyc + 2, '0});
        end else begin
          rsp_q.push_back('{cyc + 3, model[req_addr]});
        end
      end
    end
  end

  // Response back-pressure: 0 = always ready, 1 = random, 2 = stalled.
  initial forever begin
    @(posedge clock);
    #1;
    case (rdy_mode)
      0:       rsp_ready = 1'b1;
      1:       rsp_ready = 1'($urandom_range(0, 1));
      default: rsp_ready = 1'b0;
    endcase
  end

  // Present a request and hold it until accepted; returns 1 time unit after
  // the accepting edge with req_valid dropped.
  task automatic issue(input bit op, input int a, input int d);
    int k;
    req_op    = op;
    req_addr  = a[AW-1:0];
    req_wdata = d[DW-1:0];
    req_valid = 1'b1;
    for (k = 0; k < 200; k++) begin
      @(negedge clock);
      if (req_ready) break;
    end
    if (k == 200) fail1("accept_timeout");
    @(posedge clock);
    #1;
    req_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int k;
    for (int i = 0; i < NA; i++) begin
      mem[i]   = 8'hFF;
      model[i] = 8'hFF;
    end
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;

    // Read every address (all zero after init fill, else preload).
    for (int a = 0; a < NA; a++) issue(OP_RD, a, 0);

    // Write then read back the same address.
    issue(OP_WR, 2, 8'hA5);
    issue(OP_RD, 2, 0);

    // Fill ascending, read back descending.
    for (int a = 0; a < NA; a++) issue(OP_WR, a, 8'h11 * (a + 1));
    for (int a = NA - 1; a >= 0; a--) issue(OP_RD, a, 0);

    // Sustained throughput with req_valid held: 3 cycles/write, 4/read.
    issue(OP_WR, 0, 8'h3C);
    t0 = cyc;
    issue(OP_WR, 1, 8'hC3);
    chk("thru_write", cyc - t0, 3);
    issue(OP_RD, 0, 0);
    t0 = cyc;
    issue(OP_RD, 1, 0);
    chk("thru_read", cyc - t0, 4);

    // Stalled read response.
    issue(OP_WR, 1, 8'h5A);
    issue(OP_RD, 1, 0);
    rdy_mode = 2;
    for (k = 0; k < 20; k++) begin
      @(negedge clock);
      if (rsp_valid) break;
    end
    if (k == 20) fail1("stall_rsp_timeout");
    repeat (5) begin
      @(negedge clock);
      chk("stall_valid", rsp_valid, 1);
      chk("stall_rdata", rsp_rdata, 8'h5A);
      chk("stall_ready", req_ready, 0);
      chk("stall_no_wr", mem_wr,    0);
    end
    rdy_mode = 0;

    // Reset while the read is in RD_ISSUE aborts it.
    issue(OP_RD, 3, 0);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    chk("abort_rsp_valid", rsp_valid, 0);
    chk("abort_mem_wr",    mem_wr,    (INIT_N > 0) ? 1 : 0);
    chk("abort_req_ready", req_ready, (INIT_N > 0) ? 0 : 1);

    // Randomized traffic with random back-pressure and idle gaps.
    rdy_mode = 1;
    repeat (150) begin
      issue(1'($urandom_range(0, 1)), $urandom_range(0, NA - 1), $urandom_range(0, 255));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clock);
        #1;
      end
    end
    rdy_mode = 0;

    for (k = 0; k < 100; k++) begin
      @(negedge clock);
      if (rsp_q.size() == 0 && !have_cur && wr_q.size() == 0) break;
    end
    chk("drain", rsp_q.size() + int'(have_cur) + wr_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

endmodule
